// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Brief    : RV32I decode stage with a 2-entry skid buffer toward execute.
//            Optional macro DECODE_ILLEGAL_TRAP_EN flags illegal encodings.
// Revision : 1.0
// ============================================================================
module instr_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [31:0]     o_imm,
    output logic [3:0]      o_alu_op,
    output logic            o_alu_src_imm,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_illegal
);

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [3:0] c_alu_add    = 4'd0;
    localparam logic [3:0] c_alu_sub    = 4'd1;
    localparam logic [3:0] c_alu_pass_b = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic [3:0]      alu_op;
        logic            alu_src_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101)
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_funct3 = alt ? 4'd1 : 4'd0;
            3'b001:  alu_from_funct3 = 4'd2;
            3'b010:  alu_from_funct3 = 4'd3;
            3'b011:  alu_from_funct3 = 4'd4;
            3'b100:  alu_from_funct3 = 4'd5;
            3'b101:  alu_from_funct3 = alt ? 4'd7 : 4'd6;
            3'b110:  alu_from_funct3 = 4'd8;
            default: alu_from_funct3 = 4'd9;
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_sign;
    entry_t     w_dec;

    assign w_opcode = i_if_instr[6:0];
    assign w_funct3 = i_if_instr[14:12];
    assign w_funct7 = i_if_instr[31:25];
    assign w_sign   = i_if_instr[31];

    always_comb begin
        w_dec       = '0;
        w_dec.pc    = i_if_pc;
        w_dec.rd    = i_if_instr[11:7];
        w_dec.rs1   = i_if_instr[19:15];
        w_dec.rs2   = i_if_instr[24:20];
        case (w_opcode)
            c_op_r: begin
                w_dec.alu_op    = alu_from_funct3(w_funct3, w_funct7[5]);
                w_dec.reg_write = 1'b1;
                if (w_funct7 != 7'h00 && w_funct7 != 7'h20)
                    w_dec.illegal = 1'b1;
                if (w_funct7 == 7'h20 && w_funct3 != 3'b000 && w_funct3 != 3'b101)
                    w_dec.illegal = 1'b1;
            end
            c_op_i: begin
                w_dec.imm         = {{20{w_sign}}, i_if_instr[31:20]};
                w_dec.alu_op      = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            c_op_load: begin
                w_dec.imm         = {{20{w_sign}}, i_if_instr[31:20]};
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.illegal     = (w_funct3 != 3'b010);
            end
            c_op_store: begin
                w_dec.imm         = {{20{w_sign}}, i_if_instr[31:25], i_if_instr[11:7]};
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_write   = 1'b1;
                w_dec.illegal     = (w_funct3 != 3'b010);
            end
            c_op_branch: begin
                w_dec.imm    = {{19{w_sign}}, w_sign, i_if_instr[7], i_if_instr[30:25],
                                i_if_instr[11:8], 1'b0};
                w_dec.alu_op = c_alu_sub;
                w_dec.branch = 1'b1;
            end
            c_op_jal: begin
                w_dec.imm         = {{11{w_sign}}, w_sign, i_if_instr[19:12], i_if_instr[20],
                                     i_if_instr[30:21], 1'b0};
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
            end
            c_op_jalr: begin
                w_dec.imm         = {{20{w_sign}}, i_if_instr[31:20]};
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.jump        = 1'b1;
            end
            c_op_lui: begin
                w_dec.imm         = {i_if_instr[31:12], 12'b0};
                w_dec.alu_op      = c_alu_pass_b;
                w_dec.alu_src_imm = 1'b1;
                w_dec.reg_write   = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (w_dec.illegal) begin
            w_dec.reg_write = 1'b0;
            w_dec.mem_read  = 1'b0;
            w_dec.mem_write = 1'b0;
            w_dec.branch    = 1'b0;
            w_dec.jump      = 1'b0;
        end
`else
        // Illegal words become a NOP that never reports itself
        if (w_dec.illegal) begin
            w_dec.imm         = '0;
            w_dec.alu_op      = c_alu_add;
            w_dec.alu_src_imm = 1'b0;
            w_dec.reg_write   = 1'b0;
            w_dec.mem_read    = 1'b0;
            w_dec.mem_write   = 1'b0;
            w_dec.branch      = 1'b0;
            w_dec.jump        = 1'b0;
            w_dec.illegal     = 1'b0;
        end
`endif
    end

    state_t r_state;
    logic   r_if_ready;
    logic   r_id_valid;
    entry_t r_m;
    entry_t r_s;
    logic   w_accept;
    logic   w_take;

    assign w_accept = i_if_valid && r_if_ready;
    assign w_take   = r_id_valid && i_id_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_EMPTY;
            r_if_ready <= 1'b1;
            r_id_valid <= 1'b0;
            r_m        <= '0;
            r_m.pc     <= RESET_PC;
            r_s        <= '0;
        end else if (i_flush) begin
            r_state    <= ST_EMPTY;
            r_if_ready <= 1'b1;
            r_id_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_m        <= w_dec;
                        r_id_valid <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_take) begin
                        r_m <= w_dec;
                    end else if (w_accept) begin
                        r_s        <= w_dec;
                        r_if_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_take) begin
                        r_id_valid <= 1'b0;
                        r_state    <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_take) begin
                        r_m        <= r_s;
                        r_if_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_if_ready <= 1'b1;
                    r_id_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_ready    = r_if_ready;
    assign o_id_valid    = r_id_valid;
    assign o_pc          = r_m.pc;
    assign o_rd          = r_m.rd;
    assign o_rs1         = r_m.rs1;
    assign o_rs2         = r_m.rs2;
    assign o_imm         = r_m.imm;
    assign o_alu_op      = r_m.alu_op;
    assign o_alu_src_imm = r_m.alu_src_imm;
    assign o_reg_write   = r_m.reg_write;
    assign o_mem_read    = r_m.mem_read;
    assign o_mem_write   = r_m.mem_write;
    assign o_branch      = r_m.branch;
    assign o_jump        = r_m.jump;
    assign o_illegal     = r_m.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_stage
// Brief    : Directed self-checking bench for instr_decode_stage.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_instr_decode_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0080;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_if_valid = 1'b0;
    logic        o_if_ready;
    logic [31:0] i_if_instr = '0;
    logic [31:0] i_if_pc = '0;
    logic        o_id_valid;
    logic        i_id_ready = 1'b1;
    logic [31:0] o_pc;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [31:0] o_imm;
    logic [3:0]  o_alu_op;
    logic        o_alu_src_imm, o_reg_write, o_mem_read, o_mem_write;
    logic        o_branch, o_jump, o_illegal;

    int checks = 0;
    int failures = 0;

    instr_decode_stage #(.XLEN(32), .RESET_PC(c_reset_pc)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_instr(i_if_instr),
        .i_if_pc(i_if_pc), .o_id_valid(o_id_valid), .i_id_ready(i_id_ready),
        .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm),
        .o_alu_op(o_alu_op), .o_alu_src_imm(o_alu_src_imm), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_branch(o_branch),
        .o_jump(o_jump), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one instruction for a single edge (stage must be ready)
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        i_if_valid = 1'b1;
        i_if_instr = instr;
        i_if_pc    = pc;
        tick();
        i_if_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        tick();
        checks++; if (o_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_id_valid); end
        checks++; if (o_if_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_if_ready); end
        checks++; if (o_pc !== c_reset_pc) begin failures++; $display("FAIL reset_pc got=%h exp=%h", o_pc, c_reset_pc); end
        checks++; if ({o_imm, o_reg_write, o_illegal, o_alu_op} !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {o_imm, o_reg_write, o_illegal, o_alu_op}); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        i_id_ready = 1'b1;
        send(32'h00500093, 32'h100);
        checks++; if (o_id_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", o_id_valid); end
        checks++; if ({o_rd, o_rs1} !== {5'd1, 5'd0}) begin failures++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", o_rd, o_rs1); end
        checks++; if (o_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", o_imm); end
        checks++; if ({o_alu_op, o_alu_src_imm, o_reg_write} !== {4'd0, 1'b1, 1'b1}) begin failures++; $display("FAIL addi_ctrl got op=%0d src=%0b rw=%0b exp op=0 src=1 rw=1", o_alu_op, o_alu_src_imm, o_reg_write); end
        checks++; if (o_pc !== 32'h100) begin failures++; $display("FAIL addi_pc got=%h exp=100", o_pc); end
        tick();
        checks++; if (o_id_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0b exp=0", o_id_valid); end
    endtask

    task automatic test_rtype();
        send(32'h402081B3, 32'h104);
        checks++; if ({o_rd, o_rs1, o_rs2} !== {5'd3, 5'd1, 5'd2}) begin failures++; $display("FAIL sub_regs got rd=%0d rs1=%0d rs2=%0d exp 3 1 2", o_rd, o_rs1, o_rs2); end
        checks++; if ({o_alu_op, o_alu_src_imm, o_reg_write, o_imm} !== {4'd1, 1'b0, 1'b1, 32'd0}) begin failures++; $display("FAIL sub_ctrl got op=%0d src=%0b rw=%0b imm=%h exp op=1 src=0 rw=1 imm=0", o_alu_op, o_alu_src_imm, o_reg_write, o_imm); end
        send(32'h4020D093, 32'h108);
        checks++; if (o_alu_op !== 4'd7) begin failures++; $display("FAIL srai_op got=%0d exp=7", o_alu_op); end
    endtask

    task automatic test_branch_store();
        send(32'hFE208CE3, 32'h10C);
        checks++; if (o_imm !== 32'hFFFF_FFF8) begin failures++; $display("FAIL beq_imm got=%h exp=fffffff8", o_imm); end
        checks++; if ({o_branch, o_alu_op, o_reg_write, o_alu_src_imm} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin failures++; $display("FAIL beq_ctrl got br=%0b op=%0d rw=%0b src=%0b exp 1 1 0 0", o_branch, o_alu_op, o_reg_write, o_alu_src_imm); end
        send(32'h0020A623, 32'h110);
        checks++; if (o_imm !== 32'd12) begin failures++; $display("FAIL sw_imm got=%h exp=c", o_imm); end
        checks++; if ({o_mem_write, o_mem_read, o_reg_write, o_alu_op, o_alu_src_imm} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b1}) begin failures++; $display("FAIL sw_ctrl got mw=%0b mr=%0b rw=%0b op=%0d src=%0b exp 1 0 0 0 1", o_mem_write, o_mem_read, o_reg_write, o_alu_op, o_alu_src_imm); end
    endtask

    task automatic test_upper_jump();
        send(32'h123450B7, 32'h114);
        checks++; if ({o_imm, o_alu_op, o_reg_write} !== {32'h12345000, 4'd10, 1'b1}) begin failures++; $display("FAIL lui got imm=%h op=%0d rw=%0b exp imm=12345000 op=10 rw=1", o_imm, o_alu_op, o_reg_write); end
        send(32'h008000EF, 32'h118);
        checks++; if ({o_imm, o_jump, o_reg_write, o_alu_op} !== {32'd8, 1'b1, 1'b1, 4'd0}) begin failures++; $display("FAIL jal got imm=%h j=%0b rw=%0b op=%0d exp imm=8 j=1 rw=1 op=0", o_imm, o_jump, o_reg_write, o_alu_op); end
        tick();
    endtask

    task automatic test_back_to_back();
        i_id_ready = 1'b0;
        i_if_valid = 1'b1; i_if_instr = 32'h00100093; i_if_pc = 32'h200;
        tick();
        checks++; if (o_if_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%0b exp=1", o_if_ready); end
        i_if_instr = 32'h00200113; i_if_pc = 32'h204;
        tick();
        checks++; if (o_if_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_two got=%0b exp=0", o_if_ready); end
        i_if_instr = 32'h00300193; i_if_pc = 32'h208;
        tick();
        checks++; if ({o_id_valid, o_pc, o_rd, o_if_ready} !== {1'b1, 32'h200, 5'd1, 1'b0}) begin failures++; $display("FAIL bp_hold got v=%0b pc=%h rd=%0d rdy=%0b exp 1 200 1 0", o_id_valid, o_pc, o_rd, o_if_ready); end
        i_id_ready = 1'b1;
        tick();
        checks++; if ({o_id_valid, o_pc, o_imm, o_if_ready} !== {1'b1, 32'h204, 32'd2, 1'b1}) begin failures++; $display("FAIL bp_second got v=%0b pc=%h imm=%h rdy=%0b exp 1 204 2 1", o_id_valid, o_pc, o_imm, o_if_ready); end
        tick();
        i_if_valid = 1'b0;
        checks++; if ({o_id_valid, o_pc, o_rd, o_imm} !== {1'b1, 32'h208, 5'd3, 32'd3}) begin failures++; $display("FAIL bp_third got v=%0b pc=%h rd=%0d imm=%h exp 1 208 3 3", o_id_valid, o_pc, o_rd, o_imm); end
        tick();
        checks++; if (o_id_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%0b exp=0", o_id_valid); end
    endtask

    task automatic test_flush();
        i_id_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200113, 32'h304);
        i_flush = 1'b1; i_if_valid = 1'b1; i_if_instr = 32'h00300193; i_if_pc = 32'h308;
        tick();
        checks++; if ({o_id_valid, o_if_ready} !== 2'b01) begin failures++; $display("FAIL flush_two got v=%0b rdy=%0b exp v=0 rdy=1", o_id_valid, o_if_ready); end
        i_flush = 1'b0;
        send(32'h00100093, 32'h30C);
        i_flush = 1'b1; i_if_valid = 1'b1; i_if_pc = 32'h310;
        tick();
        i_flush = 1'b0; i_if_valid = 1'b0;
        checks++; if ({o_id_valid, o_if_ready} !== 2'b01) begin failures++; $display("FAIL flush_accept got v=%0b rdy=%0b exp v=0 rdy=1", o_id_valid, o_if_ready); end
        i_id_ready = 1'b1;
        send(32'h402081B3, 32'h400);
        checks++; if ({o_id_valid, o_pc, o_rd, o_alu_op} !== {1'b1, 32'h400, 5'd3, 4'd1}) begin failures++; $display("FAIL flush_after got v=%0b pc=%h rd=%0d op=%0d exp 1 400 3 1", o_id_valid, o_pc, o_rd, o_alu_op); end
        tick();
    endtask

    task automatic test_mid_reset();
        i_id_ready = 1'b0;
        send(32'h00100093, 32'h500);
        send(32'h00200113, 32'h504);
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++; if ({o_id_valid, o_if_ready, o_pc} !== {1'b0, 1'b1, c_reset_pc}) begin failures++; $display("FAIL mid_reset got v=%0b rdy=%0b pc=%h exp 0 1 %h", o_id_valid, o_if_ready, o_pc, c_reset_pc); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        i_id_ready = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        send(32'hFFFFFFFF, 32'h600);
        checks++; if (o_id_valid !== 1'b1) begin failures++; $display("FAIL ill_valid got=%0b exp=1", o_id_valid); end
        checks++; if ({o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump} !== 5'b0) begin failures++; $display("FAIL ill_ctrl got=%b exp=00000", {o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump}); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++; if (o_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%0b exp=1", o_illegal); end
`else
        checks++; if ({o_illegal, o_imm, o_alu_op, o_alu_src_imm} !== '0) begin failures++; $display("FAIL ill_nop got ill=%0b imm=%h op=%0d src=%0b exp all 0", o_illegal, o_imm, o_alu_op, o_alu_src_imm); end
`endif
        send(32'h00008083, 32'h604);
        checks++; if ({o_reg_write, o_mem_read} !== 2'b00) begin failures++; $display("FAIL lb_ctrl got rw=%0b mr=%0b exp 0 0", o_reg_write, o_mem_read); end
`ifdef DECODE_ILLEGAL_TRAP_EN
        checks++; if (o_illegal !== 1'b1) begin failures++; $display("FAIL lb_flag got=%0b exp=1", o_illegal); end
`endif
        send(32'h0000A083, 32'h608);
        checks++; if ({o_reg_write, o_mem_read, o_illegal} !== 3'b110) begin failures++; $display("FAIL lw_ctrl got rw=%0b mr=%0b ill=%0b exp 1 1 0", o_reg_write, o_mem_read, o_illegal); end
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_branch_store();
        test_upper_jump();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
